// File: rtl/mul_unit_ctrl.sv
// Issue/retire controller around a free-running, non-stallable unsigned multiplier.
// Converts RV32M operands to magnitudes, tracks ops through the multiplier, sign-fixes results into a credit-guarded FIFO.
module mul_unit_ctrl #(
    parameter int OPERAND_SIZE = 32,
    parameter int MUL_LATENCY  = 4,
    parameter int TAG_W        = 5,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [OPERAND_SIZE-1:0]   req_a_i,
    input  logic [OPERAND_SIZE-1:0]   req_b_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    input  logic                      flush_i,
    output logic [OPERAND_SIZE-1:0]   mul_x_o,
    output logic [OPERAND_SIZE-1:0]   mul_y_o,
    input  logic [2*OPERAND_SIZE-1:0] mul_result_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [OPERAND_SIZE-1:0]   resp_data_o,
    output logic [TAG_W-1:0]          resp_tag_o,
    output logic                      busy_o
);

    localparam int W  = OPERAND_SIZE;
    localparam int W2 = 2 * OPERAND_SIZE;
    localparam int L  = MUL_LATENCY;
    localparam int D  = OUT_DEPTH;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    // Handshake: a request moves when req_valid_i && req_ready_o at a rising edge;
    // a response moves when resp_valid_o && resp_ready_i at a rising edge.
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          pop;
    logic          push;

    assign req_ready_o = !rst_i && !flush_i && (cnt_q < DEPTH_C);
    assign accept      = req_valid_i && req_ready_o;

    logic          a_sgn;
    logic          b_sgn;
    logic          neg;
    logic [W-1:0]  x_mag;
    logic [W-1:0]  y_mag;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (req_op_i)
            2'b01:   begin a_sgn = req_a_i[W-1]; b_sgn = req_b_i[W-1]; end
            2'b10:   a_sgn = req_a_i[W-1];
            default: ;
        endcase
        x_mag = a_sgn ? ((~req_a_i) + W'(1)) : req_a_i;
        y_mag = b_sgn ? ((~req_b_i) + W'(1)) : req_b_i;
        neg   = a_sgn ^ b_sgn;
    end

    // Tracking pipe shifts every cycle in lock-step with the multiplier.
    logic [L-1:0]     p_vld;
    logic [L-1:0]     p_high;
    logic [L-1:0]     p_neg;
    logic [TAG_W-1:0] p_tag [L];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mul_x_o <= '0;
            mul_y_o <= '0;
            p_vld   <= '0;
            p_high  <= '0;
            p_neg   <= '0;
            for (int i = 0; i < L; i++) p_tag[i] <= '0;
        end else begin
            if (accept) begin
                mul_x_o <= x_mag;
                mul_y_o <= y_mag;
            end
            p_vld[0]  <= accept;
            p_high[0] <= |req_op_i;
            p_neg[0]  <= neg;
            p_tag[0]  <= req_tag_i;
            for (int i = 1; i < L; i++) begin
                p_vld[i]  <= p_vld[i-1];
                p_high[i] <= p_high[i-1];
                p_neg[i]  <= p_neg[i-1];
                p_tag[i]  <= p_tag[i-1];
            end
            if (flush_i) p_vld <= '0;
        end
    end

    // The product for the tail op is present on mul_result_i while that op sits in the tail stage.
    logic [W2-1:0] prod_fix;
    logic [W-1:0]  push_data;

    assign push      = p_vld[L-1];
    assign prod_fix  = p_neg[L-1] ? ((~mul_result_i) + W2'(1)) : mul_result_i;
    assign push_data = p_high[L-1] ? prod_fix[W2-1:W] : prod_fix[W-1:0];

    // Output FIFO: shift-down storage so the head (entry 0) is always a register.
    logic [D-1:0]     f_vld_q,  f_vld_d;
    logic [W-1:0]     f_data_q [D];
    logic [W-1:0]     f_data_d [D];
    logic [TAG_W-1:0] f_tag_q  [D];
    logic [TAG_W-1:0] f_tag_d  [D];
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]    wr_pos;

    assign pop = f_vld_q[0] && resp_ready_i;

    always_comb begin
        f_vld_d    = f_vld_q;
        f_data_d   = f_data_q;
        f_tag_d    = f_tag_q;
        wr_pos     = fifo_cnt_q;
        if (pop) begin
            for (int i = 0; i < D - 1; i++) begin
                f_vld_d[i]  = f_vld_q[i+1];
                f_data_d[i] = f_data_q[i+1];
                f_tag_d[i]  = f_tag_q[i+1];
            end
            f_vld_d[D-1] = 1'b0;
            wr_pos       = fifo_cnt_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < D; i++) begin
                if (CW'(i) == wr_pos) begin
                    f_vld_d[i]  = 1'b1;
                    f_data_d[i] = push_data;
                    f_tag_d[i]  = p_tag[L-1];
                end
            end
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        if (flush_i) begin
            f_vld_d    = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_vld_q    <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < D; i++) begin
                f_data_q[i] <= '0;
                f_tag_q[i]  <= '0;
            end
        end else begin
            f_vld_q    <= f_vld_d;
            fifo_cnt_q <= fifo_cnt_d;
            f_data_q   <= f_data_d;
            f_tag_q    <= f_tag_d;
        end
    end

    // Credits cover both in-flight ops and buffered results, so a retiring op always has a slot.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) cnt_q <= '0;
        else                  cnt_q <= cnt_q + CW'(accept) - CW'(pop);
    end

    assign resp_valid_o = f_vld_q[0];
    assign resp_data_o  = f_data_q[0];
    assign resp_tag_o   = f_tag_q[0];
    assign busy_o       = (cnt_q != '0);

endmodule
